// File: rtl/pic_priority_ctrl.sv
// -----------------------------------------------------------------------------
// pic_priority_ctrl
//
// Clocked interrupt priority controller. Owns the interrupt request (IRR) and
// in-service (ISR) registers plus the rotating-priority pointer. Resolves the
// winning request against masks and in-service levels, runs the acknowledge
// handshake with the INTA sequencer, and executes EOI / rotate commands.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ir_in               synchronised request lines
//   level_trig          1 = level capture, 0 = rising-edge capture
//   imr                 per-channel mask (1 = masked)
//   special_mask_mode   masked ISR bits stop blocking lower levels
//   special_nest_mode   top in-service level does not block itself
//   auto_eoi            acknowledge does not set ISR
//   auto_rotate         with auto_eoi, acknowledged level becomes lowest
//   cmd_valid/op/level  command strobe, opcode, level operand
//   ack                 acknowledge pulse
//   int_req/int_level   registered request to the CPU and winning level
//   ack_done            pulse the cycle after an ack
//   ack_level/spurious  result of the last ack
//   irr, isr            register readback
//   lowest_prio         current lowest-priority level
// -----------------------------------------------------------------------------
module pic_priority_ctrl #(
   parameter int unsigned N_CHAN = 8,
   parameter int unsigned LW     = $clog2(N_CHAN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CHAN-1:0] ir_in,
   input  logic              level_trig,
   input  logic [N_CHAN-1:0] imr,
   input  logic              special_mask_mode,
   input  logic              special_nest_mode,
   input  logic              auto_eoi,
   input  logic              auto_rotate,
   input  logic              cmd_valid,
   input  logic [2:0]        cmd_op,
   input  logic [LW-1:0]     cmd_level,
   input  logic              ack,
   output logic              int_req,
   output logic [LW-1:0]     int_level,
   output logic              ack_done,
   output logic [LW-1:0]     ack_level,
   output logic              ack_spurious,
   output logic [N_CHAN-1:0] irr,
   output logic [N_CHAN-1:0] isr,
   output logic [LW-1:0]     lowest_prio
);

   localparam logic [2:0] OpNsEoi    = 3'd1;
   localparam logic [2:0] OpSEoi     = 3'd2;
   localparam logic [2:0] OpRotNsEoi = 3'd3;
   localparam logic [2:0] OpRotSEoi  = 3'd4;
   localparam logic [2:0] OpSetPrio  = 3'd5;

   // Rotated position value meaning "no bit set".
   localparam logic [LW:0] PosNone = (LW+1)'(N_CHAN);

   // Rotated position (0 = highest priority) of the highest-priority set bit.
   function automatic logic [LW:0] first_pos(input logic [N_CHAN-1:0] vec,
                                             input logic [LW-1:0]     lowest);
      logic [LW:0]   pos;
      logic [LW-1:0] lvl;
      pos = PosNone;
      // Descending scan so the smallest rotated position is kept last.
      for (int j = N_CHAN - 1; j >= 0; j--) begin
         lvl = lowest + LW'(j) + LW'(1);
         if (vec[lvl]) pos = (LW+1)'(j);
      end
      return pos;
   endfunction

   logic [N_CHAN-1:0] irr_q, irr_d;
   logic [N_CHAN-1:0] isr_q, isr_d;
   logic [N_CHAN-1:0] ir_prev_q;
   logic [LW-1:0]     lowest_q, lowest_d;
   logic              int_req_q, int_req_d;
   logic [LW-1:0]     int_level_q, int_level_d;
   logic              ack_done_q;
   logic [LW-1:0]     ack_level_q, ack_level_d;
   logic              ack_spurious_q, ack_spurious_d;

   logic [N_CHAN-1:0] req_vec;
   logic [N_CHAN-1:0] blk_vec;
   logic [LW:0]       req_pos;
   logic [LW:0]       blk_pos;
   logic [LW:0]       isr_pos;
   logic              win_valid;
   logic [LW-1:0]     win_level;
   logic              isr_any;
   logic [LW-1:0]     isr_top;
   logic              ack_hit;
   logic              cmd_low_we;
   logic [LW-1:0]     cmd_low_val;

   // Priority resolution on current state.
   always_comb begin
      req_vec   = irr_q & ~imr;
      blk_vec   = special_mask_mode ? (isr_q & ~imr) : isr_q;
      req_pos   = first_pos(req_vec, lowest_q);
      blk_pos   = first_pos(blk_vec, lowest_q);
      win_valid = (req_pos != PosNone) &&
                  ((req_pos < blk_pos) || (special_nest_mode && (req_pos == blk_pos)));
      win_level = lowest_q + req_pos[LW-1:0] + LW'(1);
      isr_pos   = first_pos(isr_q, lowest_q);
      isr_any   = (isr_pos != PosNone);
      isr_top   = lowest_q + isr_pos[LW-1:0] + LW'(1);
   end

   // Next-state for request, in-service and rotation state.
   always_comb begin
      ack_hit     = ack && int_req_q;
      cmd_low_we  = 1'b0;
      cmd_low_val = lowest_q;

      irr_d = level_trig ? ir_in : (irr_q | (ir_in & ~ir_prev_q));
      if (ack_hit) irr_d[int_level_q] = 1'b0;

      // EOI works on the pre-ack ISR; the ack set is applied afterwards so it wins.
      isr_d = isr_q;
      if (cmd_valid) begin
         case (cmd_op)
            OpNsEoi: begin
               if (isr_any) isr_d[isr_top] = 1'b0;
            end
            OpSEoi: begin
               isr_d[cmd_level] = 1'b0;
            end
            OpRotNsEoi: begin
               if (isr_any) begin
                  isr_d[isr_top] = 1'b0;
                  cmd_low_we     = 1'b1;
                  cmd_low_val    = isr_top;
               end
            end
            OpRotSEoi: begin
               isr_d[cmd_level] = 1'b0;
               cmd_low_we       = 1'b1;
               cmd_low_val      = cmd_level;
            end
            OpSetPrio: begin
               cmd_low_we  = 1'b1;
               cmd_low_val = cmd_level;
            end
            default: ;
         endcase
      end
      if (ack_hit && !auto_eoi) isr_d[int_level_q] = 1'b1;

      // Command write of the pointer takes precedence over auto-rotate.
      lowest_d = lowest_q;
      if (ack_hit && auto_eoi && auto_rotate) lowest_d = int_level_q;
      if (cmd_low_we) lowest_d = cmd_low_val;

      // Any ack suppresses the request for one cycle.
      int_req_d   = win_valid && !ack;
      int_level_d = int_req_d ? win_level : int_level_q;

      ack_level_d    = ack_level_q;
      ack_spurious_d = ack_spurious_q;
      if (ack) begin
         ack_level_d    = ack_hit ? int_level_q : LW'(N_CHAN - 1);
         ack_spurious_d = !ack_hit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irr_q          <= '0;
         isr_q          <= '0;
         ir_prev_q      <= '0;
         lowest_q       <= LW'(N_CHAN - 1);
         int_req_q      <= 1'b0;
         int_level_q    <= '0;
         ack_done_q     <= 1'b0;
         ack_level_q    <= '0;
         ack_spurious_q <= 1'b0;
      end else begin
         irr_q          <= irr_d;
         isr_q          <= isr_d;
         ir_prev_q      <= ir_in;
         lowest_q       <= lowest_d;
         int_req_q      <= int_req_d;
         int_level_q    <= int_level_d;
         ack_done_q     <= ack;
         ack_level_q    <= ack_level_d;
         ack_spurious_q <= ack_spurious_d;
      end
   end

   assign int_req      = int_req_q;
   assign int_level    = int_level_q;
   assign ack_done     = ack_done_q;
   assign ack_level    = ack_level_q;
   assign ack_spurious = ack_spurious_q;
   assign irr          = irr_q;
   assign isr          = isr_q;
   assign lowest_prio  = lowest_q;

endmodule

// File: doc/pic_priority_ctrl.md
# pic_priority_ctrl

Parametrised, clocked interrupt priority controller for the PIC datapath, successor to the combinational 8-level priority resolver. It owns the interrupt request (IRR) and in-service (ISR) registers and the rotating-priority pointer. It provides edge/level request capture, masking, special-mask and special-fully-nested modes, an acknowledge handshake, and EOI/rotate command processing for N_CHAN channels. It sits between the IR input pins / control-register block and the INTA bus sequencer.

## Interface
- N_CHAN, 8: number of request channels; power of two, 2..32.
- LW, $clog2(N_CHAN): width of a level index.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ir_in  in  N_CHAN  raw request lines, already synchronised.
- level_trig  in  1  1 = level-triggered, 0 = edge-triggered.
- imr  in  N_CHAN  interrupt mask; 1 = channel masked.
- special_mask_mode  in  1  masked ISR bits do not block lower priorities.
- special_nest_mode  in  1  the highest in-service level does not block its own level.
- auto_eoi  in  1  acknowledge does not set ISR.
- auto_rotate  in  1  with auto_eoi, the acknowledged level becomes lowest priority.
- cmd_valid  in  1  one-cycle command strobe.
- cmd_op  in  3  0 NOP, 1 NS-EOI, 2 S-EOI, 3 rotate-on-NS-EOI, 4 rotate-on-S-EOI, 5 set-priority, 6/7 reserved (NOP).
- cmd_level  in  LW  level operand for ops 2, 4, 5.
- ack  in  1  one-cycle acknowledge pulse from the INTA sequencer.
- int_req  out  1  registered interrupt request to the CPU.
- int_level  out  LW  registered winning level; valid while int_req=1.
- ack_done  out  1  one-cycle pulse, the cycle after ack.
- ack_level  out  LW  level delivered by the last ack.
- ack_spurious  out  1  the last ack found no valid winner.
- irr, isr  out  N_CHAN  register contents, for readback.
- lowest_prio  out  LW  current lowest-priority level.

## Operation
- Reset values: irr=0, isr=0, ir_prev=0, lowest_prio=N_CHAN-1 (level 0 is highest), int_req=0, int_level=0, ack_done=0, ack_level=0, ack_spurious=0.
- IRR capture:
  - Edge mode: irr[i] is set on ir_prev[i]=0 and ir_in[i]=1, and holds until acknowledged. A line already high at reset release counts as an edge.
  - Level mode: irr[i] <= ir_in[i] every cycle.
  - Ack clears the acknowledged bit. In both modes the ack clear overrides the same-cycle set.
- Priority order: the highest-priority level is (lowest_prio+1) mod N_CHAN, descending cyclically. All compares use rotated positions; index arithmetic wraps mod N_CHAN.
- Resolution:
  - req = irr & ~imr.
  - blk = special_mask_mode ? isr & ~imr : isr.
  - Winner = highest-priority bit of req whose rotated position is strictly above the highest-priority bit of blk.
  - With special_nest_mode, equal is also allowed.
  - No winner means no request.
- Acknowledge (ack=1, int_req=1, level L=int_level):
  - irr[L] cleared.
  - isr[L] set unless auto_eoi.
  - If auto_eoi and auto_rotate, lowest_prio<=L.
  - ack_level<=L, ack_spurious<=0.
- Ack with int_req=0: no register change; ack_level<=N_CHAN-1, ack_spurious<=1.
- Commands (cmd_valid=1):
  - NS-EOI clears the highest-priority set isr bit.
  - S-EOI clears isr[cmd_level].
  - Op 3 is NS-EOI plus lowest_prio<=the cleared level.
  - Op 4 is S-EOI plus lowest_prio<=cmd_level.
  - Op 5 sets lowest_prio<=cmd_level only.
  - NS variants with isr=0 do nothing, including no rotation.
- Simultaneous command and ack:
  - EOI is evaluated on the pre-ack isr.
  - The ack set of isr wins over an EOI clear of the same bit.
  - A command write of lowest_prio wins over the auto-rotate write.

## Timing
- ir_in edge sampled at clock k: irr set at k, int_req/int_level valid after k+1.
- int_req and int_level are registered. Each cycle they are recomputed from current state with one cycle of latency.
- Ack at cycle k:
  - State updates at k.
  - int_req forced 0 at k+1, re-evaluated from k+2.
  - ack_done=1 for cycle k+1 only, with ack_level/ack_spurious valid from k+1 until the next ack.
- Command at k: isr/lowest_prio update at k; int_req reflects it from k+1.
- int_level never changes while int_req=1 unless a higher-priority request wins. The INTA sequencer samples int_level on the same edge it issues ack.
- Asynchronous reset mid-operation clears all state immediately. Pending edges are lost.

## Test plan
- N_CHAN=8, edge mode, ir_in=0x24 → int_req=1, int_level=2 two cycles later. Ack → isr=0x04, irr=0x20, int_req=0 for one cycle, then int_req=0 (5 blocked). NS-EOI → int_level=5.
- Level mode, ir_in[3] pulses 1 cycle then drops → irr[3] follows, int_req drops. Ack on a dropped request → ack_spurious=1, ack_level=7.
- Op 5 with cmd_level=4, ir_in=0x21 → winner 5 (priority 5,6,7,0…). Op 3 after ack of 5 → lowest_prio=5, isr=0.
- auto_eoi=1, auto_rotate=1, ir_in=0x81 → acks give levels 0 then 7, isr stays 0, lowest_prio=7 after second ack.
- Special mask: isr=0x02, imr=0x02, irr=0x08 → int_level=3. Same without special_mask_mode → no int_req. special_nest_mode with isr=0x08, irr=0x08 → int_level=3.
- N_CHAN=32 with lowest_prio=30 and requests 31 and 0 → winner 31 (wrap-around). rst_n low mid-ack → all outputs at reset values asynchronously.
